// File: rtl/ring_injector.sv
// Source-side ring NoC injector: picks the shortest ring direction, then emits a header and payload flits.
// Flits are registered (one cycle after launch). Credit counter gates every launch; ready signals depend only on state and credits.
package noc;
  localparam int kRingSize = 8;
  localparam int kCoordW = $clog2(kRingSize);

  typedef struct packed {
    logic [kCoordW-1:0] y;
    logic [kCoordW-1:0] x;
  } xy_t;

  typedef enum logic [1:0] {
    goLocal = 2'd0,
    goEast  = 2'd1,
    goWest  = 2'd2
  } direction_t;
endpackage

module ring_injector #(
  parameter int DataWidth  = 64,
  parameter int NumCredits = 4,
  parameter int MaxBody    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  noc::xy_t             position,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  noc::xy_t             req_dest,
  input  logic [7:0]           req_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [DataWidth-1:0] data_in,
  output logic                 out_valid,
  output logic                 out_head,
  output logic                 out_tail,
  output logic [DataWidth-1:0] out_data,
  input  logic                 credit_in
);

  localparam int CW = $clog2(NumCredits + 1);
  localparam int RW = noc::kCoordW + 1;

  typedef struct packed {
    logic [7:0]      len;
    noc::xy_t        src;
    noc::xy_t        dest;
    noc::direction_t route;
  } hdr_t;

  typedef enum logic [1:0] {INIT, IDLE, HEAD, BODY} state_t;

  state_t          state_q;
  noc::xy_t        pos_q, dest_q;
  noc::direction_t route_q, route_d;
  logic [7:0]      len_q, rem_q;
  logic [CW-1:0]   credits_q, credits_d;
  logic [RW-1:0]   cw_sum, ccw_sum, cw, ccw;
  logic            have_credit, hdr_launch, body_launch, launch;
  hdr_t            hdr;

  // Distances are formed one bit wider than a coordinate so +N never wraps.
  always_comb begin
    cw_sum  = RW'(noc::kRingSize) + RW'(req_dest.x) - RW'(pos_q.x);
    ccw_sum = RW'(noc::kRingSize) + RW'(pos_q.x) - RW'(req_dest.x);
    cw      = (cw_sum >= RW'(noc::kRingSize)) ? cw_sum - RW'(noc::kRingSize) : cw_sum;
    ccw     = (ccw_sum >= RW'(noc::kRingSize)) ? ccw_sum - RW'(noc::kRingSize) : ccw_sum;
    route_d = noc::goWest;
    if (cw == '0)       route_d = noc::goLocal;
    else if (cw <= ccw) route_d = noc::goEast;
  end

  assign have_credit = (credits_q != '0);
  assign req_ready   = (state_q == IDLE);
  assign data_ready  = (state_q == BODY) && have_credit;
  assign hdr_launch  = (state_q == HEAD) && have_credit;
  assign body_launch = data_ready && data_valid;
  assign launch      = hdr_launch || body_launch;

  always_comb begin
    credits_d = credits_q;
    case ({launch, credit_in})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = (credits_q == CW'(NumCredits)) ? credits_q : credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  assign hdr = '{len: len_q, src: pos_q, dest: dest_q, route: route_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT;
      pos_q     <= '0;
      dest_q    <= '0;
      route_q   <= noc::goLocal;
      len_q     <= '0;
      rem_q     <= '0;
      credits_q <= CW'(NumCredits);
      out_valid <= 1'b0;
      out_head  <= 1'b0;
      out_tail  <= 1'b0;
      out_data  <= '0;
    end else begin
      pos_q     <= position;
      credits_q <= credits_d;
      out_valid <= launch;
      if (hdr_launch) begin
        out_head <= 1'b1;
        out_tail <= (len_q == 8'd0);
        out_data <= DataWidth'(hdr);
      end else if (body_launch) begin
        out_head <= 1'b0;
        out_tail <= (rem_q == 8'd1);
        out_data <= data_in;
      end
      case (state_q)
        INIT: state_q <= IDLE;
        IDLE: if (req_valid) begin
          dest_q  <= req_dest;
          len_q   <= req_len;
          route_q <= route_d;
          state_q <= HEAD;
        end
        HEAD: if (have_credit) begin
          rem_q   <= len_q;
          state_q <= (len_q == 8'd0) ? IDLE : BODY;
        end
        BODY: if (body_launch) begin
          rem_q <= rem_q - 8'd1;
          if (rem_q == 8'd1) state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(credit_in && !launch && credits_q == CW'(NumCredits)));

  // An 8-bit length cannot exceed 255, so the check only exists for tighter limits.
  if (MaxBody < 255) begin : g_len_chk
    a_len_range: assert property (@(posedge clk) disable iff (!rst)
      (req_valid && req_ready) |-> (req_len <= 8'(MaxBody)));
  end

endmodule

// File: tb/tb_ring_injector.sv
// Directed bench for ring_injector: reset, routing, streaming, credit starvation, credit/launch overlap, mid-packet reset.
module tb_ring_injector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  noc::xy_t    position;
  logic        req_valid, req_ready;
  noc::xy_t    req_dest;
  logic [7:0]  req_len;
  logic        data_valid, data_ready;
  logic [63:0] data_in;
  logic        out_valid, out_head, out_tail;
  logic [63:0] out_data;
  logic        credit_in;

  int n_assert = 0;
  int n_fail   = 0;

  int         dsts[4] = '{5, 7, 6, 2};
  logic [1:0] rts[4]  = '{noc::goEast, noc::goWest, noc::goEast, noc::goLocal};

  ring_injector #(.DataWidth(64), .NumCredits(4), .MaxBody(255)) dut (
    .clk(clk), .rst(rst), .position(position),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail), .out_data(out_data),
    .credit_in(credit_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  // Header with source x fixed at 2 (y coordinates are all zero here).
  function automatic logic [63:0] hdr_exp(input logic [1:0] rt, input int dx, input int len);
    return 64'(rt) | (64'(dx) << 2) | (64'(2) << 8) | (64'(len) << 14);
  endfunction

  task automatic check_flit(input string tag, input logic head, input logic tail, input logic [63:0] dat);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".head"},  64'(out_head),  64'(head));
    chk({tag, ".tail"},  64'(out_tail),  64'(tail));
    chk({tag, ".data"},  out_data,       dat);
  endtask

  task automatic request(input int dx, input int len);
    req_valid = 1'b1;
    req_dest  = '{y: '0, x: 3'(dx)};
    req_len   = 8'(len);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    position   = '{y: '0, x: 3'd2};
    req_valid  = 1'b0;
    req_dest   = '0;
    req_len    = '0;
    data_valid = 1'b0;
    data_in    = '0;
    credit_in  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid",  64'(out_valid),  64'd0);
    chk("rst.out_head",   64'(out_head),   64'd0);
    chk("rst.out_tail",   64'(out_tail),   64'd0);
    chk("rst.out_data",   out_data,        64'd0);
    chk("rst.req_ready",  64'(req_ready),  64'd0);
    chk("rst.data_ready", 64'(data_ready), 64'd0);
    chk("rst.credits",    64'(dut.credits_q), 64'd4);

    rst = 1'b1;
    chk("init.req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle.req_ready", 64'(req_ready), 64'd1);

    // Routing from x=2, zero-length packets; each credit is handed back right away.
    for (int i = 0; i < 4; i++) begin
      request(dsts[i], 0);
      tick();
      check_flit($sformatf("route%0d", dsts[i]), 1'b1, 1'b1, hdr_exp(rts[i], dsts[i], 0));
      chk("route.req_ready", 64'(req_ready), 64'd1);
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      chk("route.gap", 64'(out_valid), 64'd0);
    end
    chk("route.credits", 64'(dut.credits_q), 64'd4);

    // len=3 streaming with data always valid.
    data_valid = 1'b1;
    data_in    = word(0);
    request(5, 3);
    chk("len3.head_cycle_data_ready", 64'(data_ready), 64'd0);
    tick();
    check_flit("len3.head", 1'b1, 1'b0, hdr_exp(noc::goEast, 5, 3));
    chk("len3.data_ready", 64'(data_ready), 64'd1);
    tick();
    data_in = word(1);
    check_flit("len3.body0", 1'b0, 1'b0, word(0));
    tick();
    data_in = word(2);
    check_flit("len3.body1", 1'b0, 1'b0, word(1));
    tick();
    check_flit("len3.tail", 1'b0, 1'b1, word(2));
    chk("len3.req_ready", 64'(req_ready), 64'd1);
    chk("len3.credits", 64'(dut.credits_q), 64'd0);
    data_valid = 1'b0;

    // Starvation: only two credits available for a four-flit packet.
    credit_in = 1'b1;
    tick();
    tick();
    credit_in = 1'b0;
    chk("starve.credits", 64'(dut.credits_q), 64'd2);
    data_valid = 1'b1;
    data_in    = word(3);
    request(7, 3);
    tick();
    check_flit("starve.head", 1'b1, 1'b0, hdr_exp(noc::goWest, 7, 3));
    tick();
    data_in = word(4);
    check_flit("starve.body0", 1'b0, 1'b0, word(3));
    chk("starve.data_ready", 64'(data_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("starve.stall%0d", i), 64'(out_valid), 64'd0);
    end
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("starve.c1", 64'(out_valid), 64'd0);
    tick();
    check_flit("starve.body1", 1'b0, 1'b0, word(4));
    data_in   = word(5);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("starve.d1", 64'(out_valid), 64'd0);
    tick();
    check_flit("starve.tail", 1'b0, 1'b1, word(5));
    chk("starve.credits_end", 64'(dut.credits_q), 64'd0);
    data_valid = 1'b0;

    // One credit, returned on every launch cycle of a len=5 packet.
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("overlap.credits_start", 64'(dut.credits_q), 64'd1);
    data_valid = 1'b1;
    data_in    = word(6);
    request(6, 5);
    credit_in = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) check_flit("overlap.head", 1'b1, 1'b0, hdr_exp(noc::goEast, 6, 5));
      else        check_flit($sformatf("overlap.body%0d", i - 1), 1'b0, (i == 5), word(5 + i));
      chk("overlap.credits", 64'(dut.credits_q), 64'd1);
      data_in   = word(6 + i);
      credit_in = (i < 5);
      tick();
    end
    chk("overlap.after", 64'(out_valid), 64'd0);
    chk("overlap.credits_end", 64'(dut.credits_q), 64'd1);
    data_valid = 1'b0;

    // Reset while the second body flit of a len=4 packet is on the output.
    credit_in = 1'b1;
    repeat (3) tick();
    credit_in = 1'b0;
    chk("rstpkt.credits_full", 64'(dut.credits_q), 64'd4);
    data_valid = 1'b1;
    data_in    = word(11);
    request(5, 4);
    tick();
    check_flit("rstpkt.head", 1'b1, 1'b0, hdr_exp(noc::goEast, 5, 4));
    tick();
    data_in = word(12);
    tick();
    check_flit("rstpkt.body1", 1'b0, 1'b0, word(12));
    rst = 1'b0;
    #1;
    chk("rstpkt.out_valid", 64'(out_valid), 64'd0);
    chk("rstpkt.credits", 64'(dut.credits_q), 64'd4);
    chk("rstpkt.req_ready", 64'(req_ready), 64'd0);
    data_valid = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstpkt.init_ready", 64'(req_ready), 64'd0);
    tick();
    chk("rstpkt.idle_ready", 64'(req_ready), 64'd1);
    chk("rstpkt.idle_credits", 64'(dut.credits_q), 64'd4);
    request(7, 0);
    tick();
    check_flit("rstpkt.new_head", 1'b1, 1'b1, hdr_exp(noc::goWest, 7, 0));
    chk("rstpkt.new_credits", 64'(dut.credits_q), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
